// File: rtl/programmable_sequence_detector_controller_if.sv
// -----------------------------------------------------------------------------
// programmable_sequence_detector_controller_if
// Groups the host programming inputs, the serial data stream, the position
// counter handshake and the controller status into one bundle.
//   slave  : the controller (consumes programming/data/count, drives the rest)
//   master : the environment (host, data source and position counter)
// Signals:
//   prog_start, prog_len, prog_bit, prog_valid : host programming request
//   data_bit, data_valid                       : serial stream under test
//   count                                      : position counter value q
//   counter_enable, counter_resetnot_sync      : position counter controls
//   state, programmed, match, error            : controller status
// -----------------------------------------------------------------------------
interface programmable_sequence_detector_controller_if #(
   parameter int CNT_W = 4
) ();
   logic             prog_start;
   logic [CNT_W-1:0] prog_len;
   logic             prog_bit;
   logic             prog_valid;
   logic             data_bit;
   logic             data_valid;
   logic [CNT_W-1:0] count;
   logic             counter_enable;
   logic             counter_resetnot_sync;
   logic [1:0]       state;
   logic             programmed;
   logic             match;
   logic             error;

   modport slave (
      input  prog_start, prog_len, prog_bit, prog_valid,
      input  data_bit, data_valid, count,
      output counter_enable, counter_resetnot_sync,
      output state, programmed, match, error
   );

   modport master (
      output prog_start, prog_len, prog_bit, prog_valid,
      output data_bit, data_valid, count,
      input  counter_enable, counter_resetnot_sync,
      input  state, programmed, match, error
   );
endinterface

// File: rtl/programmable_sequence_detector_controller.sv
// -----------------------------------------------------------------------------
// programmable_sequence_detector_controller
// Loads a serial pattern of programmable length (1..MAX_LEN) and then scans a
// serial data stream for it, steering an external position counter through
// counter_enable / counter_resetnot_sync and reading its value back on count.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave modport of programmable_sequence_detector_controller_if
//           (programming inputs, data stream, counter handshake, status)
// Status outputs state/programmed/match/error are registered; the counter
// controls are combinational so the counter moves on the same edge as the FSM.
// -----------------------------------------------------------------------------
module programmable_sequence_detector_controller #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 4
) (
   input logic clock,
   input logic reset,
   programmable_sequence_detector_controller_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PROGRAM = 2'b01,
      ST_DETECT  = 2'b10
   } state_t;

   state_t             state_r,      state_nxt_s;
   logic [MAX_LEN-1:0] pat_r,        pat_nxt_s;
   logic [CNT_W-1:0]   len_r,        len_nxt_s;
   logic               programmed_r, programmed_nxt_s;
   logic               match_r,      match_nxt_s;
   logic               error_r,      error_nxt_s;
   logic               cnt_en_s;
   logic               cnt_rstn_s;
   logic [CNT_W-1:0]   len_m1_s;
   logic               len_legal_s;
   logic               at_last_s;
   logic               cur_bit_s;

   // Selects pattern bit idx; out-of-range positions read as 0 so no
   // index ever reaches past the pattern register.
   function automatic logic pat_bit_at(input logic [MAX_LEN-1:0] pat,
                                       input logic [CNT_W-1:0]   idx);
      logic bit_v;
      bit_v = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         bit_v = (idx == CNT_W'(i)) ? pat[i] : bit_v;
      end
      return bit_v;
   endfunction

   assign len_m1_s    = len_r - {{(CNT_W-1){1'b0}}, 1'b1};
   assign len_legal_s = (bus.prog_len != {CNT_W{1'b0}}) &&
                        (bus.prog_len <= CNT_W'(MAX_LEN));
   assign at_last_s   = (bus.count == len_m1_s);
   assign cur_bit_s   = pat_bit_at(pat_r, bus.count);

   // Next-state, pattern update and counter control decode.
   always_comb begin
      state_nxt_s      = state_r;
      pat_nxt_s        = pat_r;
      len_nxt_s        = len_r;
      programmed_nxt_s = programmed_r;
      match_nxt_s      = 1'b0;
      error_nxt_s      = 1'b0;
      cnt_en_s         = 1'b0;
      cnt_rstn_s       = 1'b0;

      if (bus.prog_start) begin
         if (len_legal_s) begin
            // (Re)program: old pattern is discarded, counter cleared.
            len_nxt_s        = bus.prog_len;
            pat_nxt_s        = {MAX_LEN{1'b0}};
            programmed_nxt_s = 1'b0;
            state_nxt_s      = ST_PROGRAM;
         end else begin
            // Illegal length: flag it and keep the position where it is;
            // IDLE keeps its counter clear.
            error_nxt_s = 1'b1;
            cnt_rstn_s  = (state_r == ST_PROGRAM) || (state_r == ST_DETECT);
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_en_s   = 1'b0;
               cnt_rstn_s = 1'b0;
            end
            ST_PROGRAM: begin
               if (bus.prog_valid) begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     pat_nxt_s[i] = (bus.count == CNT_W'(i)) ? bus.prog_bit : pat_r[i];
                  end
                  if (at_last_s) begin
                     programmed_nxt_s = 1'b1;
                     state_nxt_s      = ST_DETECT;
                  end else begin
                     cnt_rstn_s = 1'b1;
                     cnt_en_s   = 1'b1;
                  end
               end else begin
                  cnt_rstn_s = 1'b1;
               end
            end
            ST_DETECT: begin
               if (bus.data_valid) begin
                  if (bus.data_bit == cur_bit_s) begin
                     if (at_last_s) begin
                        // Non-overlapping: position restarts at 0.
                        match_nxt_s = 1'b1;
                     end else begin
                        cnt_rstn_s = 1'b1;
                        cnt_en_s   = 1'b1;
                     end
                  end else begin
                     // Simple restart: the failing bit may itself start a
                     // new attempt if it equals the first pattern bit.
                     cnt_en_s = (bus.data_bit == pat_r[0]);
                  end
               end else begin
                  cnt_rstn_s = 1'b1;
               end
            end
            default: begin
               // Unused encoding behaves as IDLE and recovers to it.
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and status registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         pat_r        <= {MAX_LEN{1'b0}};
         len_r        <= {CNT_W{1'b0}};
         programmed_r <= 1'b0;
         match_r      <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         pat_r        <= pat_nxt_s;
         len_r        <= len_nxt_s;
         programmed_r <= programmed_nxt_s;
         match_r      <= match_nxt_s;
         error_r      <= error_nxt_s;
      end
   end

   assign bus.counter_enable        = cnt_en_s;
   assign bus.counter_resetnot_sync = cnt_rstn_s;
   assign bus.state                 = state_r;
   assign bus.programmed            = programmed_r;
   assign bus.match                 = match_r;
   assign bus.error                 = error_r;

endmodule

// File: tb/tb_programmable_sequence_detector_controller.sv
// -----------------------------------------------------------------------------
// tb_programmable_sequence_detector_controller
// Directed test of the sequence detector controller with a behavioural model
// of the 4-bit position counter closing the loop on count.
// -----------------------------------------------------------------------------
module tb_programmable_sequence_detector_controller;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 4;

   logic clock = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   programmable_sequence_detector_controller_if #(.CNT_W(CNT_W)) bus_if ();

   programmable_sequence_detector_controller #(
      .MAX_LEN(MAX_LEN),
      .CNT_W  (CNT_W)
   ) u_dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if.slave)
   );

   always #5 clock = ~clock;

   // Position counter model: {resetnot, enable} contract.
   always @(posedge clock) begin
      case ({bus_if.counter_resetnot_sync, bus_if.counter_enable})
         2'b00:   bus_if.count <= 4'd0;
         2'b01:   bus_if.count <= 4'd1;
         2'b11:   bus_if.count <= bus_if.count + 4'd1;
         2'b10:   bus_if.count <= bus_if.count;
         default: bus_if.count <= 4'bxxxx;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive at the falling edge, return 1 time unit after the rising edge.
   task automatic cyc(input logic rst, input logic ps, input logic [3:0] plen,
                      input logic pv, input logic pb, input logic dv, input logic db);
      @(negedge clock);
      reset             = rst;
      bus_if.prog_start = ps;
      bus_if.prog_len   = plen;
      bus_if.prog_valid = pv;
      bus_if.prog_bit   = pb;
      bus_if.data_valid = dv;
      bus_if.data_bit   = db;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic start(input logic [3:0] plen);
      cyc(1'b0, 1'b1, plen, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pbit(input logic b);
      cyc(1'b0, 1'b0, 4'd0, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic dbit(input logic b);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, b);
   endtask

   task automatic check_status(input string tag, input logic [1:0] st,
                               input logic prg, input logic [3:0] cnt);
      check_eq({tag, "_state"}, {30'd0, bus_if.state}, {30'd0, st});
      check_eq({tag, "_programmed"}, {31'd0, bus_if.programmed}, {31'd0, prg});
      check_eq({tag, "_count"}, {28'd0, bus_if.count}, {28'd0, cnt});
   endtask

   task automatic check_data(input string tag, input logic [3:0] cnt, input logic m);
      check_eq({tag, "_count"}, {28'd0, bus_if.count}, {28'd0, cnt});
      check_eq({tag, "_match"}, {31'd0, bus_if.match}, {31'd0, m});
   endtask

   logic [3:0] exp_cnt2 [5] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd0};
   logic       exp_m2   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic       strm2    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      reset             = 1'b1;
      bus_if.prog_start = 1'b0;
      bus_if.prog_len   = 4'd0;
      bus_if.prog_valid = 1'b0;
      bus_if.prog_bit   = 1'b0;
      bus_if.data_valid = 1'b0;
      bus_if.data_bit   = 1'b0;

      // Reset state
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_state", {30'd0, bus_if.state}, 32'd0);
      check_eq("rst_programmed", {31'd0, bus_if.programmed}, 32'd0);
      check_eq("rst_match", {31'd0, bus_if.match}, 32'd0);
      check_eq("rst_error", {31'd0, bus_if.error}, 32'd0);
      check_eq("rst_ctrl", {30'd0, bus_if.counter_resetnot_sync, bus_if.counter_enable}, 32'd0);
      idle();
      check_eq("rst_count", {28'd0, bus_if.count}, 32'd0);

      // Pattern 1,0,1 then stream 1,0,1
      start(4'd3);
      check_status("p101_start", 2'b01, 1'b0, 4'd0);
      pbit(1'b1);
      check_eq("p101_b0_count", {28'd0, bus_if.count}, 32'd1);
      pbit(1'b0);
      pbit(1'b1);
      check_status("p101_done", 2'b10, 1'b1, 4'd0);
      dbit(1'b1);
      check_data("s101_b0", 4'd1, 1'b0);
      dbit(1'b0);
      check_data("s101_b1", 4'd2, 1'b0);
      dbit(1'b1);
      check_data("s101_b2", 4'd0, 1'b1);
      idle();
      check_data("s101_after", 4'd0, 1'b0);

      // Pattern 1,1,0 with simple restart on stream 1,1,1,1,0
      start(4'd3);
      check_status("p110_start", 2'b01, 1'b0, 4'd0);
      pbit(1'b1);
      pbit(1'b1);
      pbit(1'b0);
      check_status("p110_done", 2'b10, 1'b1, 4'd0);
      for (int i = 0; i < 5; i++) begin
         dbit(strm2[i]);
         check_data($sformatf("s11110_b%0d", i), exp_cnt2[i], exp_m2[i]);
      end
      idle();
      check_data("s11110_after", 4'd0, 1'b0);

      // Illegal lengths 0 and 9
      start(4'd0);
      check_eq("len0_error", {31'd0, bus_if.error}, 32'd1);
      check_status("len0", 2'b10, 1'b1, 4'd0);
      idle();
      check_eq("len0_error_clr", {31'd0, bus_if.error}, 32'd0);
      start(4'd9);
      check_eq("len9_error", {31'd0, bus_if.error}, 32'd1);
      check_status("len9", 2'b10, 1'b1, 4'd0);
      idle();
      check_eq("len9_error_clr", {31'd0, bus_if.error}, 32'd0);

      // Pattern 1,0 with two idle cycles between stream bits
      start(4'd2);
      pbit(1'b1);
      pbit(1'b0);
      check_status("p10_done", 2'b10, 1'b1, 4'd0);
      for (int k = 0; k < 2; k++) begin
         dbit(1'b1);
         check_data($sformatf("gap%0d_b1", k), 4'd1, 1'b0);
         idle();
         check_data($sformatf("gap%0d_hold1a", k), 4'd1, 1'b0);
         idle();
         check_data($sformatf("gap%0d_hold1b", k), 4'd1, 1'b0);
         dbit(1'b0);
         check_data($sformatf("gap%0d_b0", k), 4'd0, 1'b1);
         idle();
         check_data($sformatf("gap%0d_hold0a", k), 4'd0, 1'b0);
         idle();
         check_data($sformatf("gap%0d_hold0b", k), 4'd0, 1'b0);
      end

      // prog_start beats a matching data bit in DETECT
      start(4'd3);
      pbit(1'b1);
      pbit(1'b1);
      pbit(1'b0);
      dbit(1'b1);
      dbit(1'b1);
      check_data("pre_restart", 4'd2, 1'b0);
      cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      check_status("restart", 2'b01, 1'b0, 4'd0);
      check_eq("restart_match", {31'd0, bus_if.match}, 32'd0);
      pbit(1'b0);
      pbit(1'b1);
      check_status("p01_done", 2'b10, 1'b1, 4'd0);
      dbit(1'b0);
      check_data("s01_b0", 4'd1, 1'b0);
      dbit(1'b1);
      check_data("s01_b1", 4'd0, 1'b1);

      // Reset in the middle of programming; prog_valid in IDLE is inert
      start(4'd4);
      pbit(1'b1);
      pbit(1'b0);
      check_status("mid_prog", 2'b01, 1'b0, 4'd2);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("midrst_state", {30'd0, bus_if.state}, 32'd0);
      check_eq("midrst_programmed", {31'd0, bus_if.programmed}, 32'd0);
      idle();
      check_status("midrst_release", 2'b00, 1'b0, 4'd0);
      pbit(1'b1);
      check_status("idle_pv0", 2'b00, 1'b0, 4'd0);
      pbit(1'b1);
      check_status("idle_pv1", 2'b00, 1'b0, 4'd0);

      // Full-length pattern uses every bit: 1,0,0,0,0,0,0,1
      start(4'd8);
      for (int i = 0; i < 8; i++) begin
         pbit((i == 0) || (i == 7));
      end
      check_status("p8_done", 2'b10, 1'b1, 4'd0);
      for (int i = 0; i < 8; i++) begin
         dbit((i == 0) || (i == 7));
      end
      check_data("s8_end", 4'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
